// File: rtl/sdff_fifo_ift_pkg.sv
// Shared information-flow-tracking definitions: label width and the label
// combining helpers used by every IFT cell.
package sdff_fifo_ift_pkg;

  localparam int TAINT_W = 32;

  typedef logic [TAINT_W-1:0] taint_t;

  function automatic taint_t taint_merge(input taint_t a, input taint_t b);
    return a | b;
  endfunction

  // data_xor is the reduction XOR of the data word; it is X whenever any bit is X.
  function automatic taint_t x_guard(input logic data_xor, input taint_t t);
    return (data_xor === 1'bx) ? '0 : t;
  endfunction

endpackage

// File: rtl/sdff_fifo_ift_cell.sv
// Data plus taint register with synchronous reset and load enable; used as
// the registered FIFO read port.
module sdff_fifo_ift_cell
  import sdff_fifo_ift_pkg::*;
#(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         srst,
  input  taint_t       srst_t,
  input  logic         en,
  input  logic [W-1:0] d,
  input  taint_t       d_t,
  output logic [W-1:0] q,
  output taint_t       q_t
);

  logic [W-1:0] q_q, q_d;
  taint_t       q_t_q, q_t_d;

  always_comb begin
    q_d   = q_q;
    q_t_d = q_t_q;
    if (en) begin
      q_d   = d;
      q_t_d = d_t;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      q_q   <= RST_VAL;
      q_t_q <= srst_t;
    end else begin
      q_q   <= q_d;
      q_t_q <= q_t_d;
    end
  end

  assign q   = q_q;
  assign q_t = q_t_q;

endmodule

// File: rtl/sdff_fifo_ift.sv
// Taint-tracking synchronous FIFO with registered read data; control outputs
// share one sticky label built from the enables and the reset.
module sdff_fifo_ift
  import sdff_fifo_ift_pkg::*;
#(
  parameter int                 WIDTH      = 2,
  parameter int                 DEPTH      = 4,
  parameter logic [WIDTH-1:0]   SRST_VALUE = '0
) (
  input  logic                       CLK,
  input  taint_t                     CLK_t,
  input  logic                       SRST,
  input  taint_t                     SRST_t,
  input  logic                       WR_EN,
  input  taint_t                     WR_EN_t,
  input  logic [WIDTH-1:0]           D,
  input  taint_t                     D_t,
  input  logic                       RD_EN,
  input  taint_t                     RD_EN_t,
  output logic [WIDTH-1:0]           Q,
  output taint_t                     Q_t,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output taint_t                     FULL_t,
  output taint_t                     EMPTY_t,
  output taint_t                     COUNT_t
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q   [DEPTH];
  logic [WIDTH-1:0] mem_d   [DEPTH];
  taint_t           mem_t_q [DEPTH];
  taint_t           mem_t_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  taint_t           ctrl_t_q, ctrl_t_d;
  logic             full, empty, push, pop;

  // The clock label is accepted for interface uniformity only.
  logic unused_clk_t;
  assign unused_clk_t = ^CLK_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A request is taken on the edge where its enable is high and the FIFO can
  // serve it; a push at FULL is still taken when a pop frees the slot on that edge.
  assign pop  = RD_EN && !empty;
  assign push = WR_EN && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    mem_t_d  = mem_t_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ctrl_t_d = taint_merge(taint_merge(ctrl_t_q, WR_EN_t), RD_EN_t);
    if (push) begin
      mem_d[wr_ptr_q]   = D;
      mem_t_d[wr_ptr_q] = x_guard(^D, taint_merge(D_t, WR_EN_t));
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
    if (SRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ctrl_t_q <= SRST_t;
      for (int i = 0; i < DEPTH; i++) begin
        mem_t_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ctrl_t_q <= ctrl_t_d;
      mem_t_q  <= mem_t_d;
    end
  end

  // Same-edge reset wins over any pending pop inside the cell.
  sdff_fifo_ift_cell #(
    .W       (WIDTH),
    .RST_VAL (SRST_VALUE)
  ) u_out_reg (
    .clk    (CLK),
    .srst   (SRST),
    .srst_t (SRST_t),
    .en     (pop),
    .d      (mem_q[rd_ptr_q]),
    .d_t    (taint_merge(mem_t_q[rd_ptr_q], RD_EN_t)),
    .q      (Q),
    .q_t    (Q_t)
  );

  assign FULL    = full;
  assign EMPTY   = empty;
  assign COUNT   = count_q;
  assign FULL_t  = ctrl_t_q;
  assign EMPTY_t = ctrl_t_q;
  assign COUNT_t = ctrl_t_q;

endmodule
